// File: rtl/huffman_table_decoder.sv
// Table-programmable canonical Huffman decoder: one bit per cycle in, (RUN, SIZE) out.
// Optional macro HUFF_ERR_EN adds the err port (one-cycle pulse on an invalid MAX_LEN code).
module huffman_table_decoder #(
    parameter int TABLE_COUNT = 4,
    parameter int MAX_LEN     = 16,
    parameter int SYM_DEPTH   = 256,
    localparam int TSEL_W = (TABLE_COUNT > 1) ? $clog2(TABLE_COUNT) : 1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int ADDR_W = $clog2(SYM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_wr_en,
    input  logic              tbl_wr_kind,
    input  logic [TSEL_W-1:0] tbl_wr_sel,
    input  logic [ADDR_W-1:0] tbl_wr_addr,
    input  logic [7:0]        tbl_wr_data,
    input  logic [TSEL_W-1:0] table_sel,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic [3:0]        r_value,
    output logic [3:0]        s_value,
    output logic [LEN_W-1:0]  code_len,
    output logic              busy
`ifdef HUFF_ERR_EN
    , output logic            err
`endif
);

    localparam int CW = MAX_LEN + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOOKUP, ST_OUT} state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     code_r, first_r;
    logic [ADDR_W-1:0] ptr_r, addr_r;
    logic [LEN_W-1:0]  len_r, clen_r;
    logic [TSEL_W-1:0] tsel_r;
    logic [7:0]        count_r [TABLE_COUNT][MAX_LEN];
    logic [7:0]        huffval_mem [TABLE_COUNT][SYM_DEPTH];

    logic              idle_s, accept_s, wr_ok_s, match_s, last_len_s, nomatch_s;
    logic [TSEL_W-1:0] cur_tsel_s;
    logic [LEN_W-1:0]  cur_len_s, step_len_s;
    logic [7:0]        cnt_s;
    logic [CW-1:0]     code_base_s, first_base_s, code_n_s, diff_s;
    logic [ADDR_W-1:0] ptr_base_s;

    assign idle_s    = (state_r == ST_IDLE);
    assign bit_ready = idle_s || (state_r == ST_SHIFT);
    assign sym_valid = (state_r == ST_OUT);
    assign busy      = !idle_s;
    assign accept_s  = bit_valid && bit_ready;
    assign wr_ok_s   = tbl_wr_en && idle_s;

    // Canonical step for the bit being offered; IDLE starts a fresh code with zeroed accumulators
    always_comb begin
        cur_tsel_s   = tsel_r;
        cur_len_s    = len_r;
        code_base_s  = code_r;
        first_base_s = first_r;
        ptr_base_s   = ptr_r;
        if (idle_s) begin
            cur_tsel_s   = table_sel;
            cur_len_s    = {LEN_W{1'b0}};
            code_base_s  = {CW{1'b0}};
            first_base_s = {CW{1'b0}};
            ptr_base_s   = {ADDR_W{1'b0}};
        end else begin
            cur_tsel_s   = tsel_r;
        end
        cnt_s = 8'd0;
        for (int t = 0; t < TABLE_COUNT; t++) begin
            for (int l = 0; l < MAX_LEN; l++) begin
                if ((cur_tsel_s == TSEL_W'(t)) && (cur_len_s == LEN_W'(l))) begin
                    cnt_s = count_r[t][l];
                end else begin
                    cnt_s = cnt_s;
                end
            end
        end
        code_n_s   = (code_base_s << 1) | CW'(bit_in);
        diff_s     = code_n_s - first_base_s;
        match_s    = (diff_s < CW'(cnt_s));
        step_len_s = cur_len_s + LEN_W'(1);
        last_len_s = (step_len_s == LEN_W'(MAX_LEN));
        nomatch_s  = accept_s && !match_s && last_len_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_SHIFT: begin
                if (accept_s) begin
                    if (match_s)         state_s = ST_LOOKUP;
                    else if (last_len_s) state_s = ST_IDLE;
                    else                 state_s = ST_SHIFT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOOKUP: state_s = ST_OUT;
            ST_OUT: begin
                if (sym_ready) state_s = ST_IDLE;
                else           state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, code accumulators and registered symbol outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            code_r   <= {CW{1'b0}};
            first_r  <= {CW{1'b0}};
            ptr_r    <= {ADDR_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            clen_r   <= {LEN_W{1'b0}};
            tsel_r   <= {TSEL_W{1'b0}};
            r_value  <= 4'd0;
            s_value  <= 4'd0;
            code_len <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                if (idle_s) tsel_r <= table_sel;
                if (match_s) begin
                    addr_r <= ptr_base_s + ADDR_W'(diff_s);
                    clen_r <= step_len_s;
                end else begin
                    first_r <= (first_base_s + CW'(cnt_s)) << 1;
                    ptr_r   <= ptr_base_s + ADDR_W'(cnt_s);
                    code_r  <= code_n_s;
                    len_r   <= step_len_s;
                end
            end
            if (state_r == ST_LOOKUP) begin
                r_value  <= huffval_mem[tsel_r][addr_r][7:4];
                s_value  <= huffval_mem[tsel_r][addr_r][3:0];
                code_len <= clen_r;
            end
        end
    end

    // BITS count tables; cleared by reset, writable only while idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int t = 0; t < TABLE_COUNT; t++)
                for (int l = 0; l < MAX_LEN; l++)
                    count_r[t][l] <= 8'd0;
        end else begin
            for (int t = 0; t < TABLE_COUNT; t++)
                for (int l = 0; l < MAX_LEN; l++)
                    if (wr_ok_s && !tbl_wr_kind && (tbl_wr_sel == TSEL_W'(t)) &&
                        (tbl_wr_addr == ADDR_W'(l)))
                        count_r[t][l] <= tbl_wr_data;
        end
    end

    // HUFFVAL symbol RAM, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok_s && tbl_wr_kind) huffval_mem[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data;
    end

`ifdef HUFF_ERR_EN
    logic err_r;
    // Invalid-code pulse, high only in the cycle after the return to IDLE
    always_ff @(posedge clk) begin
        if (!rst) err_r <= 1'b0;
        else      err_r <= nomatch_s;
    end
    assign err = err_r;
`endif

endmodule

// File: tb/tb_huffman_table_decoder.sv
// Bench for huffman_table_decoder: JPEG luma DC/AC tables, vector table plus corner sequences.
module tb_huffman_table_decoder;

    logic       clk = 1'b0;
    logic       rst, tbl_wr_en, tbl_wr_kind;
    logic [1:0] tbl_wr_sel, table_sel;
    logic [7:0] tbl_wr_addr, tbl_wr_data;
    logic       bit_in, bit_valid, bit_ready, sym_valid, sym_ready, busy;
    logic [3:0] r_value, s_value;
    logic [4:0] code_len;
`ifdef HUFF_ERR_EN
    logic       err;
`endif

    huffman_table_decoder dut (
        .clk(clk), .rst(rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_kind(tbl_wr_kind),
        .tbl_wr_sel(tbl_wr_sel), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .table_sel(table_sel), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .r_value(r_value), .s_value(s_value),
        .code_len(code_len), .busy(busy)
`ifdef HUFF_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int tsel; int len; logic [15:0] code; int r; int s;} vec_t;
    typedef struct {int r; int s; int len;} exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    logic [7:0] dc_bits[16];
    logic [7:0] ac_bits[16];
    logic [7:0] ac_vals[32];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Scoreboard: every consumed symbol must match the oldest expectation
    always @(negedge clk) begin
        if (rst && sym_valid && sym_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_sym", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sym_r", int'(r_value), e.r);
                chk("sym_s", int'(s_value), e.s);
                chk("sym_len", int'(code_len), e.len);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic kind, input int sel, input int addr, input logic [7:0] data);
        tbl_wr_en = 1'b1; tbl_wr_kind = kind; tbl_wr_sel = 2'(sel);
        tbl_wr_addr = 8'(addr); tbl_wr_data = data;
        @(posedge clk); #1;
        tbl_wr_en = 1'b0;
    endtask

    task automatic load_bits(input int sel, input logic is_ac);
        for (int i = 0; i < 16; i++) wr(1'b0, sel, i, is_ac ? ac_bits[i] : dc_bits[i]);
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bit_in = b; bit_valid = 1'b1;
        @(negedge clk);
        while (!bit_ready && n < 50) begin @(negedge clk); n++; end
        if (!bit_ready) chk("bit_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    // Drives a whole code; table_sel is flipped after the first bit and must be ignored
    task automatic send_code(input int tsel, input int len, input logic [15:0] code,
                             input int r, input int s);
        exp_t e;
        e.r = r; e.s = s; e.len = len;
        sb_q.push_back(e);
        table_sel = 2'(tsel);
        for (int i = len - 1; i >= 0; i--) begin
            send_bit(code[i]);
            table_sel = 2'(tsel ^ 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 60) begin @(negedge clk); n++; end
        chk("drain", int'(sb_q.size() == 0 && !busy), 1);
        @(posedge clk); #1;
    endtask

    task automatic set_vec(input int i, input int tsel, input int len, input logic [15:0] code,
                           input int r, input int s);
        vecs[i].tsel = tsel; vecs[i].len = len; vecs[i].code = code;
        vecs[i].r = r; vecs[i].s = s;
    endtask

    initial begin
        dc_bits = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                    8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ac_bits = '{8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3, 8'd5,
                    8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'h7d};
        ac_vals = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
                    8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
                    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
                    8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0};
        set_vec(0,  0, 3, 16'b011,       0, 2);
        set_vec(1,  0, 2, 16'b00,        0, 0);
        set_vec(2,  0, 3, 16'b110,       0, 5);
        set_vec(3,  0, 9, 16'b111111110, 0, 11);
        set_vec(4,  0, 4, 16'b1110,      0, 6);
        set_vec(5,  1, 5, 16'b11011,     1, 2);
        set_vec(6,  1, 4, 16'b1010,      0, 0);
        set_vec(7,  1, 2, 16'b01,        0, 2);
        set_vec(8,  1, 8, 16'b11111001,  2, 2);
        set_vec(9,  1, 6, 16'b111011,    4, 1);
        set_vec(10, 1, 7, 16'b1111010,   5, 1);
        set_vec(11, 1, 4, 16'b1100,      1, 1);

        rst = 1'b0; tbl_wr_en = 1'b0; tbl_wr_kind = 1'b0; tbl_wr_sel = 2'd0;
        tbl_wr_addr = 8'd0; tbl_wr_data = 8'd0; table_sel = 2'd0;
        bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bit_ready", int'(bit_ready), 1);
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_code_len", int'(code_len), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        load_bits(0, 1'b0);
        for (int i = 0; i < 12; i++) wr(1'b1, 0, i, 8'(i));
        load_bits(1, 1'b1);
        for (int i = 0; i < 32; i++) wr(1'b1, 1, i, ac_vals[i]);

        // Latency: LOOKUP in the cycle after the last bit, OUT in the one after that
        begin
            exp_t e;
            e.r = 0; e.s = 2; e.len = 3;
            sb_q.push_back(e);
            table_sel = 2'd0;
            send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
            @(negedge clk);
            chk("lat_lookup_valid", int'(sym_valid), 0);
            chk("lat_lookup_ready", int'(bit_ready), 0);
            @(negedge clk);
            chk("lat_out_valid", int'(sym_valid), 1);
            @(posedge clk); #1;
            drain();
        end

        for (int i = 0; i < 12; i++)
            send_code(vecs[i].tsel, vecs[i].len, vecs[i].code, vecs[i].r, vecs[i].s);
        drain();

        // Backpressure: outputs held, bits withheld while sym_ready is low
        begin
            exp_t e;
            e.r = 0; e.s = 2; e.len = 2;
            sb_q.push_back(e);
            sym_ready = 1'b0;
            table_sel = 2'd1;
            send_bit(1'b0); send_bit(1'b1);
            @(negedge clk); @(negedge clk);
            bit_in = 1'b1; bit_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                chk("hold_valid", int'(sym_valid), 1);
                chk("hold_ready", int'(bit_ready), 0);
                chk("hold_r", int'(r_value), 0);
                chk("hold_s", int'(s_value), 2);
                chk("hold_len", int'(code_len), 2);
                @(negedge clk);
            end
            @(posedge clk); #1;
            bit_valid = 1'b0; sym_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("release_idle", int'(busy), 0);
            @(posedge clk); #1;
        end
        send_code(1, 5, 16'b11011, 1, 2);
        drain();

        // Invalid code on an empty table: 16 ones, no symbol
        table_sel = 2'd2;
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        @(negedge clk);
        chk("inv_busy_15", int'(busy), 1);
        @(posedge clk); #1;
        send_bit(1'b1);
        @(negedge clk);
        chk("inv_idle", int'(busy), 0);
`ifdef HUFF_ERR_EN
        chk("inv_err_pulse", int'(err), 1);
`endif
        @(negedge clk);
`ifdef HUFF_ERR_EN
        chk("inv_err_clear", int'(err), 0);
`endif
        chk("inv_no_sym", int'(sym_valid), 0);
        @(posedge clk); #1;

        // Reset mid-code, then verify counts were cleared and HUFFVAL kept
        table_sel = 2'd1;
        send_bit(1'b1); send_bit(1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(bit_ready), 1);
        chk("mid_rst_valid", int'(sym_valid), 0);
        chk("mid_rst_r", int'(r_value), 0);
        chk("mid_rst_s", int'(s_value), 0);
        chk("mid_rst_len", int'(code_len), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        table_sel = 2'd1;
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        drain();
        load_bits(0, 1'b0);
        load_bits(1, 1'b1);
        send_code(1, 5, 16'b11011, 1, 2);
        drain();

        // Table write while decoding must be dropped
        begin
            exp_t e;
            e.r = 1; e.s = 2; e.len = 5;
            sb_q.push_back(e);
            table_sel = 2'd1;
            send_bit(1'b1); send_bit(1'b1);
            tbl_wr_en = 1'b1; tbl_wr_kind = 1'b0; tbl_wr_sel = 2'd1;
            tbl_wr_addr = 8'd4; tbl_wr_data = 8'd0;
            send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
            tbl_wr_en = 1'b0;
            drain();
        end
        send_code(1, 5, 16'b11011, 1, 2);
        send_code(0, 3, 16'b011, 0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
